mlaccel_memarb: RTL and testbench

Arbiter and return router for the single shared main memory (mlaccel_memory) in mlaccel_top. It serves three clients:
- compute engine (cmem): absolute priority, no backpressure.
- QPI host memory engine (qmem): 16-bit accesses.
- sequencer instruction fetch (smem): 32-bit reads.
It drives the memory address/write port, then routes read data back to the issuing client with a per-client rvalid pulse a fixed MEM_LATENCY cycles after the grant. It also flags starvation of the low-priority clients.

---
 rtl/mlaccel_pkg.sv | 22 ++
 rtl/mlaccel_memarb_if.sv | 63 ++++++
 rtl/mlaccel_memarb_tagpipe.sv | 39 +++
 rtl/mlaccel_memarb.sv | 144 ++++++++++++++
 tb/tb_mlaccel_memarb.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlaccel_pkg.sv
// rtl/mlaccel_pkg.sv - shared constants and types for the mlaccel memory arbiter
package mlaccel_pkg;

    localparam int CLI_C   = 0;
    localparam int CLI_Q   = 1;
    localparam int CLI_S   = 2;
    localparam int NUM_CLI = 3;

    localparam int MEM_DATA_W = 64;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;
    localparam int QMEM_W     = 16;
    localparam int QMEM_BE_W  = QMEM_W / 8;
    localparam int SMEM_W     = 32;

    localparam int MEM_LATENCY_DEF = 2;
    localparam int STARVE_MAX_DEF  = 64;
    localparam int ADDR_W_DEF      = 16;

    // One-hot read return tag: bit CLI_C / CLI_Q / CLI_S marks the owner.
    typedef logic [NUM_CLI-1:0] tag_t;

endpackage

// File: rtl/mlaccel_memarb_if.sv
// rtl/mlaccel_memarb_if.sv - client, memory and status signals of the memory arbiter
interface mlaccel_memarb_if #(
    parameter int ADDR_W = 16
) ();
    import mlaccel_pkg::*;

    // compute engine
    logic                   c_ren;
    logic [MEM_BE_W-1:0]    c_wen;
    logic [ADDR_W-1:0]      c_addr;
    logic [MEM_DATA_W-1:0]  c_wdata;
    logic                   c_rvalid;
    logic [MEM_DATA_W-1:0]  c_rdata;

    // QPI host memory engine
    logic                   q_valid;
    logic                   q_ready;
    logic [QMEM_BE_W-1:0]   q_wen;
    logic [ADDR_W-1:0]      q_addr;
    logic [QMEM_W-1:0]      q_wdata;
    logic                   q_rvalid;
    logic [QMEM_W-1:0]      q_rdata;

    // sequencer instruction fetch
    logic                   s_valid;
    logic                   s_ready;
    logic [ADDR_W-1:0]      s_addr;
    logic                   s_rvalid;
    logic [SMEM_W-1:0]      s_rdata;

    // shared memory port
    logic [ADDR_W-1:0]      mem_addr;
    logic [MEM_BE_W-1:0]    mem_wen;
    logic [MEM_DATA_W-1:0]  mem_wdata;
    logic [MEM_DATA_W-1:0]  mem_rdata;

    logic                   starve;

    modport slave (
        input  c_ren, c_wen, c_addr, c_wdata,
        output c_rvalid, c_rdata,
        input  q_valid, q_wen, q_addr, q_wdata,
        output q_ready, q_rvalid, q_rdata,
        input  s_valid, s_addr,
        output s_ready, s_rvalid, s_rdata,
        output mem_addr, mem_wen, mem_wdata,
        input  mem_rdata,
        output starve
    );

    modport master (
        output c_ren, c_wen, c_addr, c_wdata,
        input  c_rvalid, c_rdata,
        output q_valid, q_wen, q_addr, q_wdata,
        input  q_ready, q_rvalid, q_rdata,
        output s_valid, s_addr,
        input  s_ready, s_rvalid, s_rdata,
        input  mem_addr, mem_wen, mem_wdata,
        output mem_rdata,
        input  starve
    );

endinterface

// File: rtl/mlaccel_memarb_tagpipe.sv
// rtl/mlaccel_memarb_tagpipe.sv - fixed-latency shift register carrying read return tags
module mlaccel_memarb_tagpipe
    import mlaccel_pkg::*;
#(
    parameter int DEPTH = MEM_LATENCY_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    // Each stage takes the previous one; stage 0 takes the tag of this cycle's grant.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Async clear drops every read in flight so no stale rvalid appears after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mlaccel_memarb.sv
// rtl/mlaccel_memarb.sv - shared main memory arbiter with read return routing and starvation flag
module mlaccel_memarb
    import mlaccel_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    mlaccel_memarb_if.slave   bus
);

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic                  c_act;
    logic                  grant_q;
    logic                  grant_s;

    logic                  rr_q;
    logic                  rr_d;
    logic [CNT_W-1:0]      q_wait_q;
    logic [CNT_W-1:0]      q_wait_d;
    logic [CNT_W-1:0]      s_wait_q;
    logic [CNT_W-1:0]      s_wait_d;
    logic                  starve_q;
    logic                  starve_d;

    logic [ADDR_W-1:0]     mux_addr;
    logic [MEM_BE_W-1:0]   mux_wen;
    logic [MEM_DATA_W-1:0] mux_wdata;

    tag_t                  tag_push;
    tag_t                  tag_out;

    // Compute always wins; otherwise a lone requester wins, and a tie goes to the rr favourite.
    // Nothing is granted while reset is asserted.
    always_comb begin
        c_act   = bus.c_ren | (|bus.c_wen);
        grant_q = 1'b0;
        grant_s = 1'b0;
        if (resetn && !c_act) begin
            if (bus.q_valid && (!bus.s_valid || !rr_q)) begin
                grant_q = 1'b1;
            end else if (bus.s_valid) begin
                grant_s = 1'b1;
            end
        end
    end

    // Steer the winning client onto the memory port; idle cycles park on the compute address.
    always_comb begin
        mux_addr  = bus.c_addr;
        mux_wen   = '0;
        mux_wdata = bus.c_wdata;
        if (resetn && c_act) begin
            mux_wen = bus.c_wen;
        end else if (grant_q) begin
            mux_addr  = bus.q_addr;
            mux_wen   = {{(MEM_BE_W-QMEM_BE_W){1'b0}}, bus.q_wen};
            mux_wdata = {{(MEM_DATA_W-QMEM_W){1'b0}}, bus.q_wdata};
        end else if (grant_s) begin
            mux_addr  = bus.s_addr;
            mux_wdata = '0;
        end
    end

    // Tag each granted read with its owner; a compute read+write still expects data back.
    always_comb begin
        tag_push         = '0;
        tag_push[CLI_C]  = bus.c_ren;
        tag_push[CLI_Q]  = grant_q & ~(|bus.q_wen);
        tag_push[CLI_S]  = grant_s;
    end

    // Fairness pointer moves away from whichever low-priority client was just served.
    always_comb begin
        rr_d = rr_q;
        if (grant_q) begin
            rr_d = 1'b1;
        end else if (grant_s) begin
            rr_d = 1'b0;
        end
    end

    // Waiting counters: count blocked cycles, saturate, clear on grant or on a dropped request.
    // starve is registered from the next counter values so it tracks the counters exactly.
    always_comb begin
        q_wait_d = q_wait_q;
        s_wait_d = s_wait_q;
        if (!bus.q_valid || grant_q) begin
            q_wait_d = '0;
        end else if (q_wait_q != CNT_MAX) begin
            q_wait_d = q_wait_q + CNT_W'(1);
        end
        if (!bus.s_valid || grant_s) begin
            s_wait_d = '0;
        end else if (s_wait_q != CNT_MAX) begin
            s_wait_d = s_wait_q + CNT_W'(1);
        end
        starve_d = (q_wait_d == CNT_MAX) | (s_wait_d == CNT_MAX);
    end

    // Arbiter state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_q     <= 1'b0;
            q_wait_q <= '0;
            s_wait_q <= '0;
            starve_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            q_wait_q <= q_wait_d;
            s_wait_q <= s_wait_d;
            starve_q <= starve_d;
        end
    end

    mlaccel_memarb_tagpipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tagpipe (
        .clock   (clock),
        .resetn  (resetn),
        .tag_in  (tag_push),
        .tag_out (tag_out)
    );

    assign bus.q_ready   = grant_q;
    assign bus.s_ready   = grant_s;
    assign bus.mem_addr  = mux_addr;
    assign bus.mem_wen   = mux_wen;
    assign bus.mem_wdata = mux_wdata;

    assign bus.c_rvalid  = tag_out[CLI_C];
    assign bus.q_rvalid  = tag_out[CLI_Q];
    assign bus.s_rvalid  = tag_out[CLI_S];
    assign bus.c_rdata   = bus.mem_rdata;
    assign bus.q_rdata   = bus.mem_rdata[QMEM_W-1:0];
    assign bus.s_rdata   = bus.mem_rdata[SMEM_W-1:0];

    assign bus.starve    = starve_q;

endmodule

// File: tb/tb_mlaccel_memarb.sv
// tb/tb_mlaccel_memarb.sv - self-checking bench for mlaccel_memarb
module tb_mlaccel_memarb;
    import mlaccel_pkg::*;

    localparam int LAT  = 2;
    localparam int SMAX = 64;
    localparam int AW   = 16;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    mlaccel_memarb_if #(.ADDR_W(AW)) bus ();

    mlaccel_memarb #(
        .MEM_LATENCY (LAT),
        .STARVE_MAX  (SMAX),
        .ADDR_W      (AW)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Memory environment: byte-masked writes, reads return LAT cycles after the address.
    logic [63:0] mem [0:65535];
    logic [15:0] apipe [LAT];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= {$urandom, $urandom};
    end

    always @(posedge clock) begin
        if (resetn) begin
            for (int b = 0; b < 8; b++)
                if (bus.mem_wen[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        apipe[0] <= bus.mem_addr;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end

    assign bus.mem_rdata = mem[apipe[LAT-1]];

    // Reference model: served-client rules, fairness bit, a queue of pending returns, wait counts.
    typedef struct packed {
        logic [2:0]  who;   // bit0 c, bit1 q, bit2 s
        logic [15:0] addr;
    } ret_t;

    ret_t        ret_q[$];
    ret_t        push_rec;
    logic        m_favour_s;
    int          m_wait_q, m_wait_s;

    logic        exp_qr, exp_sr, exp_starve;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wen;
    logic [63:0] exp_wdata, exp_rdata;
    logic [2:0]  exp_rv;

    task automatic model_reset();
        m_favour_s = 1'b0;
        m_wait_q   = 0;
        m_wait_s   = 0;
        ret_q.delete();
        for (int i = 0; i < LAT; i++) ret_q.push_back('0);
    endtask

    task automatic model_eval();
        logic c_act;
        c_act     = bus.c_ren | (|bus.c_wen);
        exp_qr    = 1'b0;
        exp_sr    = 1'b0;
        exp_addr  = bus.c_addr;
        exp_wen   = '0;
        exp_wdata = bus.c_wdata;
        push_rec  = '0;
        if (resetn) begin
            if (c_act) begin
                exp_wen       = bus.c_wen;
                push_rec.who  = {2'b00, bus.c_ren};
                push_rec.addr = bus.c_addr;
            end else if (bus.q_valid && !(bus.s_valid && m_favour_s)) begin
                exp_qr        = 1'b1;
                exp_addr      = bus.q_addr;
                exp_wen       = {6'b0, bus.q_wen};
                exp_wdata     = {48'b0, bus.q_wdata};
                push_rec.who  = {1'b0, (bus.q_wen == 2'b00), 1'b0};
                push_rec.addr = bus.q_addr;
            end else if (bus.s_valid) begin
                exp_sr        = 1'b1;
                exp_addr      = bus.s_addr;
                push_rec.who  = 3'b100;
                push_rec.addr = bus.s_addr;
            end
        end
        exp_rv     = resetn ? ret_q[0].who : 3'b000;
        exp_rdata  = mem[ret_q[0].addr];
        exp_starve = (m_wait_q >= SMAX) || (m_wait_s >= SMAX);
    endtask

    task automatic model_commit();
        ret_t old;
        if (!resetn) begin
            model_reset();
        end else begin
            ret_q.push_back(push_rec);
            old = ret_q.pop_front();
            if (exp_qr) m_favour_s = 1'b1;
            else if (exp_sr) m_favour_s = 1'b0;
            m_wait_q = (bus.q_valid && !exp_qr) ? ((m_wait_q < SMAX) ? m_wait_q + 1 : SMAX) : 0;
            m_wait_s = (bus.s_valid && !exp_sr) ? ((m_wait_s < SMAX) ? m_wait_s + 1 : SMAX) : 0;
        end
    endtask

    task automatic step();
        model_commit();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.c_ren = 0; bus.c_wen = '0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.q_valid = 0; bus.q_wen = '0; bus.q_addr = '0; bus.q_wdata = '0;
        bus.s_valid = 0; bus.s_addr = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    function automatic logic [29:0] obs_vec();
        return {bus.q_ready, bus.s_ready, bus.mem_addr, bus.mem_wen,
                bus.c_rvalid, bus.q_rvalid, bus.s_rvalid, bus.starve};
    endfunction

    function automatic logic [29:0] exp_vec();
        return {exp_qr, exp_sr, exp_addr, exp_wen, exp_rv[0], exp_rv[1], exp_rv[2], exp_starve};
    endfunction

    function automatic logic [63:0] rd_got();
        if (exp_rv[0]) return bus.c_rdata;
        if (exp_rv[1]) return {48'b0, bus.q_rdata};
        return {32'b0, bus.s_rdata};
    endfunction

    function automatic logic [63:0] rd_want();
        if (exp_rv[0]) return exp_rdata;
        if (exp_rv[1]) return {48'b0, exp_rdata[15:0]};
        return {32'b0, exp_rdata[31:0]};
    endfunction

    task automatic test_reset();
        idle_inputs();
        bus.c_ren = 1; bus.c_wen = 8'hFF; bus.q_valid = 1; bus.s_valid = 1;
        resetn = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            n_tests++;
            if ({bus.q_ready, bus.s_ready, bus.mem_wen, bus.c_rvalid, bus.q_rvalid, bus.s_rvalid, bus.starve} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_zero cyc%0d got wen=%h qr=%b sr=%b st=%b want all 0",
                         i, bus.mem_wen, bus.q_ready, bus.s_ready, bus.starve);
            end
            step();
        end
        idle_inputs();
        resetn = 1'b1;
    endtask

    task automatic test_q_read();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i == 0) begin
                bus.c_wen = 8'hFF; bus.c_addr = 16'h0010; bus.c_wdata = 64'hDEAD_BEEF_CAFE_1234;
            end
            if (i == 1) begin
                bus.q_valid = 1; bus.q_addr = 16'h0010;
            end
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL q_read cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                n_tests++;
                if (bus.q_ready !== 1'b1 || bus.mem_addr !== 16'h0010) begin
                    n_fail++;
                    $display("FAIL q_read_grant got ready=%b addr=%h want 1 0010", bus.q_ready, bus.mem_addr);
                end
            end
            if (i == 3) begin
                n_tests++;
                if (bus.q_rvalid !== 1'b1 || bus.q_rdata !== 16'h1234 || bus.c_rvalid !== 1'b0 || bus.s_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL q_read_return got qrv=%b qrd=%h crv=%b srv=%b want 1 1234 0 0",
                             bus.q_rvalid, bus.q_rdata, bus.c_rvalid, bus.s_rvalid);
                end
            end
            step();
        end
    endtask

    task automatic test_c_preempt();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i < 2) begin
                bus.q_valid = 1; bus.q_addr = 16'h0234; bus.q_wen = 2'b11; bus.q_wdata = 16'hA5C3;
            end
            if (i == 0) begin
                bus.c_wen = 8'hFF; bus.c_addr = 16'h0100; bus.c_wdata = {$urandom, $urandom};
            end
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL c_preempt cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (exp_wen != 0) begin
                n_tests++;
                if (bus.mem_wdata !== exp_wdata) begin
                    n_fail++;
                    $display("FAIL c_preempt_wdata cyc%0d got %h want %h", i, bus.mem_wdata, exp_wdata);
                end
            end
            if (i == 0) begin
                n_tests++;
                if (bus.mem_addr !== 16'h0100 || bus.q_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL c_preempt_block got addr=%h qr=%b want 0100 0", bus.mem_addr, bus.q_ready);
                end
            end
            if (i == 1) begin
                n_tests++;
                if (bus.mem_addr !== 16'h0234 || bus.q_ready !== 1'b1 || bus.mem_wen !== 8'h03) begin
                    n_fail++;
                    $display("FAIL c_preempt_next got addr=%h qr=%b wen=%h want 0234 1 03",
                             bus.mem_addr, bus.q_ready, bus.mem_wen);
                end
            end
            step();
        end
    endtask

    task automatic test_alternate();
        idle_inputs();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            idle_inputs();
            if (i < 8) begin
                bus.q_valid = 1; bus.q_addr = 16'h2000;
                bus.s_valid = 1; bus.s_addr = 16'h3000;
            end
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL alternate cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (exp_rv != 0) begin
                n_tests++;
                if (rd_got() !== rd_want()) begin
                    n_fail++;
                    $display("FAIL alternate_rdata cyc%0d got %h want %h", i, rd_got(), rd_want());
                end
            end
            if (i < 8) begin
                n_tests++;
                if (bus.q_ready !== (i % 2 == 0) || bus.s_ready !== (i % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL alternate_order cyc%0d got qr=%b sr=%b want qr=%b", i, bus.q_ready, bus.s_ready, (i % 2 == 0));
                end
            end
            if (i >= 2 && i < 10) begin
                n_tests++;
                if (bus.q_rvalid !== (i % 2 == 0) || bus.s_rvalid !== (i % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL alternate_returns cyc%0d got qrv=%b srv=%b want qrv=%b", i, bus.q_rvalid, bus.s_rvalid, (i % 2 == 0));
                end
            end
            step();
        end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 75; i++) begin
            idle_inputs();
            if (i < 70) begin
                bus.c_ren = 1; bus.c_addr = 16'(i);
            end
            if (i <= 70) begin
                bus.s_valid = 1; bus.s_addr = 16'h4444;
            end
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL starve cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (exp_rv != 0) begin
                n_tests++;
                if (rd_got() !== rd_want()) begin
                    n_fail++;
                    $display("FAIL starve_rdata cyc%0d got %h want %h", i, rd_got(), rd_want());
                end
            end
            if (i == 63 || i == 64 || i == 69 || i == 71) begin
                n_tests++;
                if (bus.starve !== (i == 64 || i == 69)) begin
                    n_fail++;
                    $display("FAIL starve_flag cyc%0d got %b want %b", i, bus.starve, (i == 64 || i == 69));
                end
            end
            if (i == 70) begin
                n_tests++;
                if (bus.s_ready !== 1'b1 || bus.starve !== 1'b1) begin
                    n_fail++;
                    $display("FAIL starve_release got sr=%b st=%b want 1 1", bus.s_ready, bus.starve);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] wq, ws;
        wq = mem[16'h0700];
        ws = mem[16'h0900];
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i == 0) begin bus.c_ren = 1; bus.c_addr = 16'h0500; end
            if (i == 1) begin bus.q_valid = 1; bus.q_addr = 16'h0700; end
            if (i == 2) begin bus.s_valid = 1; bus.s_addr = 16'h0900; end
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (exp_rv != 0) begin
                n_tests++;
                if (rd_got() !== rd_want()) begin
                    n_fail++;
                    $display("FAIL back_to_back_rdata cyc%0d got %h want %h", i, rd_got(), rd_want());
                end
            end
            if (i >= 2 && i <= 4) begin
                n_tests++;
                if ({bus.c_rvalid, bus.q_rvalid, bus.s_rvalid} !== (3'b100 >> (i - 2))) begin
                    n_fail++;
                    $display("FAIL back_to_back_order cyc%0d got crv/qrv/srv=%b%b%b want %b",
                             i, bus.c_rvalid, bus.q_rvalid, bus.s_rvalid, 3'b100 >> (i - 2));
                end
            end
            if (i == 3) begin
                n_tests++;
                if (bus.q_rdata !== wq[15:0]) begin
                    n_fail++;
                    $display("FAIL back_to_back_qdata got %h want %h", bus.q_rdata, wq[15:0]);
                end
            end
            if (i == 4) begin
                n_tests++;
                if (bus.s_rdata !== ws[31:0]) begin
                    n_fail++;
                    $display("FAIL back_to_back_sdata got %h want %h", bus.s_rdata, ws[31:0]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i == 0) begin bus.q_valid = 1; bus.q_addr = 16'h0055; end
            if (i == 1) begin
                bus.q_valid = 1; bus.q_addr = 16'h0066; bus.s_valid = 1; bus.c_wen = 8'hFF;
                resetn = 1'b0;
                model_reset();
            end
            if (i == 2) begin
                resetn = 1'b1;
                bus.q_valid = 1; bus.q_addr = 16'h0066; bus.s_valid = 1; bus.s_addr = 16'h0077;
            end
            if (i == 3) begin bus.s_valid = 1; bus.s_addr = 16'h0077; end
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_inflight cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                n_tests++;
                if ({bus.q_ready, bus.s_ready, bus.mem_wen, bus.c_rvalid, bus.q_rvalid, bus.s_rvalid, bus.starve} !== 14'd0) begin
                    n_fail++;
                    $display("FAIL reset_inflight_zero got wen=%h qr=%b sr=%b want 0", bus.mem_wen, bus.q_ready, bus.s_ready);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (bus.q_rvalid !== 1'b0 || bus.q_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_inflight_after got qrv=%b qr=%b sr=%b want 0 1 0",
                             bus.q_rvalid, bus.q_ready, bus.s_ready);
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        logic qp, sp;
        qp = 0; sp = 0;
        idle_inputs();
        for (int i = 0; i < 300; i++) begin
            bus.c_ren = ($urandom_range(0, 3) == 0);
            bus.c_wen = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            bus.c_addr = 16'($urandom);
            bus.c_wdata = {$urandom, $urandom};
            if (qp && $urandom_range(0, 7) == 0) qp = 0;
            else if (!qp && $urandom_range(0, 1) == 0) begin
                qp = 1;
                bus.q_addr = 16'($urandom);
                bus.q_wen = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                bus.q_wdata = 16'($urandom);
            end
            if (sp && $urandom_range(0, 7) == 0) sp = 0;
            else if (!sp && $urandom_range(0, 1) == 0) begin
                sp = 1;
                bus.s_addr = 16'($urandom);
            end
            bus.q_valid = qp;
            bus.s_valid = sp;
            @(negedge clock);
            model_eval();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (exp_rv != 0) begin
                n_tests++;
                if (rd_got() !== rd_want()) begin
                    n_fail++;
                    $display("FAIL random_rdata cyc%0d got %h want %h", i, rd_got(), rd_want());
                end
            end
            if (exp_wen != 0) begin
                n_tests++;
                if (bus.mem_wdata !== exp_wdata) begin
                    n_fail++;
                    $display("FAIL random_wdata cyc%0d got %h want %h", i, bus.mem_wdata, exp_wdata);
                end
            end
            if (exp_qr) qp = 0;
            if (exp_sr) sp = 0;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        @(posedge clock);
        #1;
        test_reset();
        test_q_read();
        test_c_preempt();
        test_alternate();
        test_starve();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
